// File: rtl/rename_map_table.sv
// N-way register alias table: in-order lane acceptance against freelist grants, intra-bundle bypass,
// and restore from the architectural map on recovery. Define RAT_READY_BITS_EN to add per-tag ready bits.
module rename_map_table #(
  parameter int unsigned N          = 3,
  parameter int unsigned PR_COUNT   = 64,
  parameter int unsigned ARCH_COUNT = 32,
  localparam int unsigned PT = $clog2(PR_COUNT),
  localparam int unsigned AW = $clog2(ARCH_COUNT)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N-1:0]             disp_valid,
  input  logic [N-1:0]             disp_has_dest,
  input  logic [N*AW-1:0]          disp_dest_arch,
  input  logic [N*AW-1:0]          disp_src1_arch,
  input  logic [N*AW-1:0]          disp_src2_arch,
  input  logic [N*PT-1:0]          free_tag,
  input  logic [N-1:0]             free_tag_valid,
  output logic [N-1:0]             alloc_req,
  output logic [N-1:0]             lane_accept,
  output logic [N*PT-1:0]          src1_tag,
  output logic [N*PT-1:0]          src2_tag,
  output logic [N-1:0]             src1_ready,
  output logic [N-1:0]             src2_ready,
  output logic [N*PT-1:0]          new_dest_tag,
  output logic [N*PT-1:0]          old_dest_tag,
  input  logic [N-1:0]             cdb_valid,
  input  logic [N*PT-1:0]          cdb_tag,
  input  logic                     recover,
  input  logic [ARCH_COUNT*PT-1:0] arch_map
);

  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

  logic [PT-1:0] r_map [ARCH_COUNT];

  logic [AW-1:0] w_dest [N];
  logic [AW-1:0] w_src1 [N];
  logic [AW-1:0] w_src2 [N];
  logic [PT-1:0] w_ftag [N];
  logic [PT-1:0] w_new  [N];
  logic [N-1:0]  w_req;
  logic [N-1:0]  w_acc;
  logic [N-1:0]  w_wr;
  logic          w_hold;

  assign w_hold      = reset | recover;
  assign alloc_req   = w_req;
  assign lane_accept = w_acc;
  assign w_wr        = w_acc & w_req;

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      w_dest[i] = disp_dest_arch[i*AW +: AW];
      w_src1[i] = disp_src1_arch[i*AW +: AW];
      w_src2[i] = disp_src2_arch[i*AW +: AW];
      w_ftag[i] = free_tag[i*PT +: PT];
    end
  end

  // k counts requesting lanes below i, so each allocating lane takes the next
  // freelist entry; the first lane without a grant blocks every younger lane.
  always_comb begin
    logic [KW-1:0] k;
    logic          blocked;
    k       = '0;
    blocked = 1'b0;
    w_req   = '0;
    w_acc   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_new[i] = '0;
      w_req[i] = disp_valid[i] & disp_has_dest[i] & (w_dest[i] != '0) & ~w_hold;
      if (disp_valid[i] && !w_hold && !blocked) begin
        if (w_req[i] && !free_tag_valid[k]) begin
          blocked = 1'b1;
        end else begin
          w_acc[i] = 1'b1;
          if (w_req[i]) w_new[i] = w_ftag[k];
        end
      end
      if (w_req[i]) k = k + 1'b1;
    end
  end

`ifdef RAT_READY_BITS_EN
  logic [PR_COUNT-1:0] r_ready;

  function automatic logic cdb_hit(input logic [PT-1:0] t);
    logic h;
    h = 1'b0;
    for (int unsigned c = 0; c < N; c++)
      if (cdb_valid[c] && (cdb_tag[c*PT +: PT] == t)) h = 1'b1;
    return h;
  endfunction
`else
  logic w_unused_cdb;
  assign w_unused_cdb = ^{cdb_valid, cdb_tag};
`endif

  always_comb begin
    logic [PT-1:0] t1, t2, to;
    logic          b1, b2;
    src1_tag     = '0;
    src2_tag     = '0;
    src1_ready   = '0;
    src2_ready   = '0;
    new_dest_tag = '0;
    old_dest_tag = '0;
    for (int unsigned j = 0; j < N; j++) begin
      t1 = r_map[w_src1[j]];
      t2 = r_map[w_src2[j]];
      to = r_map[w_dest[j]];
      b1 = 1'b0;
      b2 = 1'b0;
      // Scanning oldest to youngest leaves the youngest older writer in place.
      for (int unsigned i = 0; i < j; i++) begin
        if (w_wr[i]) begin
          if (w_dest[i] == w_src1[j]) begin t1 = w_new[i]; b1 = 1'b1; end
          if (w_dest[i] == w_src2[j]) begin t2 = w_new[i]; b2 = 1'b1; end
          if (w_dest[i] == w_dest[j]) to = w_new[i];
        end
      end
      if (w_src1[j] == '0) t1 = '0;
      if (w_src2[j] == '0) t2 = '0;
      src1_tag[j*PT +: PT]     = t1;
      src2_tag[j*PT +: PT]     = t2;
      new_dest_tag[j*PT +: PT] = w_new[j];
      old_dest_tag[j*PT +: PT] = w_wr[j] ? to : '0;
`ifdef RAT_READY_BITS_EN
      src1_ready[j] = (w_src1[j] == '0) | (~b1 & (r_ready[t1] | cdb_hit(t1)));
      src2_ready[j] = (w_src2[j] == '0) | (~b2 & (r_ready[t2] | cdb_hit(t2)));
`else
      src1_ready[j] = 1'b0 & b1;
      src2_ready[j] = 1'b0 & b2;
`endif
    end
  end

  // Later lanes are written last, so the youngest writer of an arch reg wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned a = 0; a < ARCH_COUNT; a++) r_map[a] <= PT'(a);
    end else if (recover) begin
      for (int unsigned a = 0; a < ARCH_COUNT; a++) r_map[a] <= arch_map[a*PT +: PT];
    end else begin
      for (int unsigned i = 0; i < N; i++)
        if (w_wr[i]) r_map[w_dest[i]] <= w_new[i];
    end
  end

`ifdef RAT_READY_BITS_EN
  always_ff @(posedge clock) begin
    if (reset || recover) begin
      r_ready <= '1;
    end else begin
      for (int unsigned c = 0; c < N; c++)
        if (cdb_valid[c]) r_ready[cdb_tag[c*PT +: PT]] <= 1'b1;
      // Clears follow sets so a fresh allocation overrides a same-tag broadcast.
      for (int unsigned i = 0; i < N; i++)
        if (w_wr[i]) r_ready[w_new[i]] <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_rename_map_table.sv
// Directed bench for rename_map_table (N=3, 64 physical, 32 arch registers).
module tb_rename_map_table;
  localparam int N = 3, PT = 6, AW = 5, AC = 32;
`ifdef RAT_READY_BITS_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif

  logic clock = 1'b0, reset, recover;
  logic [N-1:0] disp_valid, disp_has_dest, free_tag_valid, cdb_valid;
  logic [N*AW-1:0] disp_dest_arch, disp_src1_arch, disp_src2_arch;
  logic [N*PT-1:0] free_tag, cdb_tag;
  logic [N-1:0] alloc_req, lane_accept, src1_ready, src2_ready;
  logic [N*PT-1:0] src1_tag, src2_tag, new_dest_tag, old_dest_tag;
  logic [AC*PT-1:0] arch_map;
  int checks = 0, failures = 0;

  rename_map_table #(.N(N), .PR_COUNT(64), .ARCH_COUNT(AC)) dut (
    .clock(clock), .reset(reset), .disp_valid(disp_valid), .disp_has_dest(disp_has_dest),
    .disp_dest_arch(disp_dest_arch), .disp_src1_arch(disp_src1_arch), .disp_src2_arch(disp_src2_arch),
    .free_tag(free_tag), .free_tag_valid(free_tag_valid), .alloc_req(alloc_req),
    .lane_accept(lane_accept), .src1_tag(src1_tag), .src2_tag(src2_tag),
    .src1_ready(src1_ready), .src2_ready(src2_ready), .new_dest_tag(new_dest_tag),
    .old_dest_tag(old_dest_tag), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .recover(recover), .arch_map(arch_map));

  always #5 clock = ~clock;

  function automatic logic [31:0] tg(input logic [N*PT-1:0] v, input int l);
    return {26'b0, v[l*PT +: PT]};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic lane(input int l, input bit v, input bit hd, input int d, input int s1, input int s2);
    disp_valid[l] = v;
    disp_has_dest[l] = hd;
    disp_dest_arch[l*AW +: AW] = AW'(d);
    disp_src1_arch[l*AW +: AW] = AW'(s1);
    disp_src2_arch[l*AW +: AW] = AW'(s2);
  endtask

  task automatic ftags(input int t0, input int t1, input int t2, input logic [2:0] v);
    free_tag = {PT'(t2), PT'(t1), PT'(t0)};
    free_tag_valid = v;
  endtask

  // Commit at the posedge, then drive the next vector 1 time unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; recover = 1'b0; cdb_valid = '0; cdb_tag = '0; arch_map = '0;
    for (int l = 0; l < N; l++) lane(l, 1, 1, l + 1, 0, 0);
    ftags(32, 33, 34, 3'b111);
    tick(); #1;
    chk("reset_accept", 32'(lane_accept), 0);
    chk("reset_alloc", 32'(alloc_req), 0);
    tick();
    reset = 1'b0;

    // Plain lookup after reset
    lane(0, 1, 0, 0, 5, 0); lane(1, 0, 0, 0, 0, 0); lane(2, 0, 0, 0, 0, 0);
    #1;
    chk("lk_src1_tag", tg(src1_tag, 0), 5);
    chk("lk_src2_tag", tg(src2_tag, 0), 0);
    chk("lk_src1_rdy", 32'(src1_ready[0]), RB);
    chk("lk_src2_rdy", 32'(src2_ready[0]), RB);
    chk("lk_accept", 32'(lane_accept), 3'b001);
    chk("lk_alloc", 32'(alloc_req), 0);
    chk("lk_new0", tg(new_dest_tag, 0), 0);
    tick();

    // Three allocating lanes
    lane(0, 1, 1, 1, 0, 0); lane(1, 1, 1, 2, 0, 0); lane(2, 1, 1, 3, 0, 0);
    ftags(32, 33, 34, 3'b111);
    #1;
    chk("a3_accept", 32'(lane_accept), 3'b111);
    chk("a3_alloc", 32'(alloc_req), 3'b111);
    for (int l = 0; l < N; l++) begin
      chk($sformatf("a3_new%0d", l), tg(new_dest_tag, l), 32 + l);
      chk($sformatf("a3_old%0d", l), tg(old_dest_tag, l), 1 + l);
    end
    tick();

    lane(0, 1, 0, 0, 1, 4); lane(1, 1, 0, 0, 2, 0); lane(2, 1, 0, 0, 3, 0);
    #1;
    for (int l = 0; l < N; l++) begin
      chk($sformatf("map%0d", l + 1), tg(src1_tag, l), 32 + l);
      chk($sformatf("map_rdy%0d", l + 1), 32'(src1_ready[l]), 0);
    end
    chk("map4", tg(src2_tag, 0), 4);
    chk("map4_rdy", 32'(src2_ready[0]), RB);
    tick();

    // Intra-bundle bypass with two writers of x7
    lane(0, 1, 1, 7, 0, 0); lane(1, 1, 0, 0, 7, 0); lane(2, 1, 1, 7, 0, 0);
    ftags(40, 41, 50, 3'b111);
    #1;
    chk("byp_accept", 32'(lane_accept), 3'b111);
    chk("byp_alloc", 32'(alloc_req), 3'b101);
    chk("byp_new0", tg(new_dest_tag, 0), 40);
    chk("byp_old0", tg(old_dest_tag, 0), 7);
    chk("byp_src1_l1", tg(src1_tag, 1), 40);
    chk("byp_rdy_l1", 32'(src1_ready[1]), 0);
    chk("byp_new1", tg(new_dest_tag, 1), 0);
    chk("byp_new2", tg(new_dest_tag, 2), 41);
    chk("byp_old2", tg(old_dest_tag, 2), 40);
    tick();

    // Partial stall: only two grants
    lane(0, 1, 1, 8, 7, 0); lane(1, 1, 1, 9, 0, 0); lane(2, 1, 1, 10, 0, 0);
    ftags(42, 43, 44, 3'b011);
    #1;
    chk("map7", tg(src1_tag, 0), 41);
    chk("stall_accept", 32'(lane_accept), 3'b011);
    chk("stall_alloc", 32'(alloc_req), 3'b111);
    chk("stall_new1", tg(new_dest_tag, 1), 43);
    chk("stall_old1", tg(old_dest_tag, 1), 9);
    chk("stall_new2", tg(new_dest_tag, 2), 0);
    tick();

    // Non-allocating middle lane: lane 2 takes free_tag[1]
    lane(0, 1, 1, 11, 0, 0); lane(1, 1, 0, 0, 10, 9); lane(2, 1, 1, 12, 0, 0);
    ftags(45, 46, 47, 3'b111);
    #1;
    chk("gap_accept", 32'(lane_accept), 3'b111);
    chk("gap_alloc", 32'(alloc_req), 3'b101);
    chk("gap_new0", tg(new_dest_tag, 0), 45);
    chk("gap_new2", tg(new_dest_tag, 2), 46);
    chk("gap_old2", tg(old_dest_tag, 2), 12);
    chk("gap_src10", tg(src1_tag, 1), 10);
    chk("gap_src10_rdy", 32'(src1_ready[1]), RB);
    chk("gap_src9", tg(src2_tag, 1), 43);
    chk("gap_src9_rdy", 32'(src2_ready[1]), 0);
    tick();

    // Same-cycle CDB wakeup
    lane(0, 1, 0, 0, 7, 0); lane(1, 1, 0, 0, 1, 0); lane(2, 1, 0, 0, 2, 0);
    cdb_valid = 3'b011; cdb_tag = {PT'(0), PT'(32), PT'(41)};
    #1;
    chk("cdb_tag0", tg(src1_tag, 0), 41);
    chk("cdb_rdy0", 32'(src1_ready[0]), RB);
    chk("cdb_rdy1", 32'(src1_ready[1]), RB);
    chk("cdb_rdy2", 32'(src1_ready[2]), 0);
    tick();
    cdb_valid = '0;
    #1;
    chk("cdb_reg_rdy0", 32'(src1_ready[0]), RB);
    chk("cdb_reg_rdy1", 32'(src1_ready[1]), RB);
    chk("cdb_reg_rdy2", 32'(src1_ready[2]), 0);
    tick();

    // Recovery from the architectural map
    for (int a = 0; a < AC; a++) arch_map[a*PT +: PT] = PT'(a);
    arch_map[7*PT +: PT] = PT'(12);
    lane(0, 1, 1, 1, 0, 0); lane(1, 1, 1, 2, 0, 0); lane(2, 1, 1, 3, 0, 0);
    ftags(32, 33, 34, 3'b111);
    recover = 1'b1;
    #1;
    chk("rec_accept", 32'(lane_accept), 0);
    chk("rec_alloc", 32'(alloc_req), 0);
    tick();
    recover = 1'b0;
    lane(0, 1, 0, 0, 7, 11); lane(1, 1, 0, 0, 8, 0); lane(2, 1, 0, 0, 1, 0);
    #1;
    chk("rec_map7", tg(src1_tag, 0), 12);
    chk("rec_rdy7", 32'(src1_ready[0]), RB);
    chk("rec_map8", tg(src1_tag, 1), 8);
    chk("rec_map1", tg(src1_tag, 2), 1);
    chk("rec_rdy1", 32'(src1_ready[2]), RB);
    chk("rec_map11", tg(src2_tag, 0), 11);
    tick();

    // Invalid lane and x0 destination never allocate
    lane(0, 0, 1, 5, 0, 0); lane(1, 1, 1, 5, 5, 0); lane(2, 1, 1, 0, 5, 0);
    ftags(60, 61, 62, 3'b111);
    #1;
    chk("x0_alloc", 32'(alloc_req), 3'b010);
    chk("x0_accept", 32'(lane_accept), 3'b110);
    chk("x0_new1", tg(new_dest_tag, 1), 60);
    chk("x0_old1", tg(old_dest_tag, 1), 5);
    chk("x0_src_l1", tg(src1_tag, 1), 5);
    chk("x0_new2", tg(new_dest_tag, 2), 0);
    chk("x0_old2", tg(old_dest_tag, 2), 0);
    chk("x0_src_l2", tg(src1_tag, 2), 60);
    chk("x0_rdy_l2", 32'(src1_ready[2]), 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
